// File: rtl/ppi_bus_sequencer.sv
// Round-robin host bus master for an 8255-style PPI: serialises two requesters
// onto CS/RD/WR/A/D with programmable setup, strobe and hold phase lengths.
module ppi_bus_sequencer #(
   parameter int SETUP  = 1,
   parameter int STROBE = 2,
   parameter int HOLD   = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  REQ,
   input  logic [1:0]  REQ_WR,
   input  logic [3:0]  REQ_A,
   input  logic [15:0] REQ_D,
   output logic [1:0]  GNT,
   output logic [7:0]  RD_DATA,
   output logic        BUSY,
   output logic        CS,
   output logic        RD,
   output logic        WR,
   output logic [1:0]  A,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic [7:0]  D_IN
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

   // Phase counters load length-1 and the phase ends when they reach zero.
   localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ptr_q, ptr_d;
   logic        win_q, win_d;
   logic        is_wr_q, is_wr_d;
   logic [1:0]  a_q, a_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d, busy_q, busy_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        active;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      is_wr_d = is_wr_q;
      a_d     = a_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (|REQ) begin
               // ptr_q names the requester that was not served last
               win_d   = (REQ == 2'b11) ? ptr_q : REQ[1];
               is_wr_d = REQ_WR[win_d];
               a_d     = win_d ? REQ_A[3:2] : REQ_A[1:0];
               dout_d  = win_d ? REQ_D[15:8] : REQ_D[7:0];
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               if (!is_wr_q) rdata_d = D_IN;
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            ptr_d   = ~win_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pins are decoded from the next state so every output comes straight off a flop.
      active = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      cs_d   = !active;
      rd_d   = !((state_d == S_STROBE) && !is_wr_d);
      wr_d   = !((state_d == S_STROBE) && is_wr_d);
      oe_d   = active && is_wr_d;
      gnt_d  = (state_d == S_DONE) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         is_wr_q <= 1'b0;
         a_q     <= 2'b00;
         dout_q  <= 8'h00;
         rdata_q <= 8'h00;
         cs_q    <= 1'b1;
         rd_q    <= 1'b1;
         wr_q    <= 1'b1;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         gnt_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         is_wr_q <= is_wr_d;
         a_q     <= a_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         cs_q    <= cs_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         gnt_q   <= gnt_d;
      end
   end

   assign GNT     = gnt_q;
   assign RD_DATA = rdata_q;
   assign BUSY    = busy_q;
   assign CS      = cs_q;
   assign RD      = rd_q;
   assign WR      = wr_q;
   assign A       = a_q;
   assign D_OUT   = dout_q;
   assign D_OE    = oe_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Bench for ppi_bus_sequencer: directed scenarios plus randomized transactions
// checked against a phase-timing model of the PPI bus cycle.
module tb_ppi_bus_sequencer;

   logic        CLK, RST;
   logic [1:0]  REQ, REQ_WR;
   logic [3:0]  REQ_A;
   logic [15:0] REQ_D;
   logic [7:0]  D_IN;

   logic [1:0] gnt0, a0, gnt2, a2;
   logic [7:0] rdd0, dout0, rdd2, dout2;
   logic       busy0, cs0, rd0, wr0, oe0, busy2, cs2, rd2, wr2, oe2;

   int n_chk = 0;
   int n_fail = 0;

   ppi_bus_sequencer dut0 (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_A(REQ_A), .REQ_D(REQ_D),
      .GNT(gnt0), .RD_DATA(rdd0), .BUSY(busy0), .CS(cs0), .RD(rd0), .WR(wr0),
      .A(a0), .D_OUT(dout0), .D_OE(oe0), .D_IN(D_IN));

   ppi_bus_sequencer #(.SETUP(3), .STROBE(1), .HOLD(4)) dut2 (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_A(REQ_A), .REQ_D(REQ_D),
      .GNT(gnt2), .RD_DATA(rdd2), .BUSY(busy2), .CS(cs2), .RD(rd2), .WR(wr2),
      .A(a2), .D_OUT(dout2), .D_OE(oe2), .D_IN(D_IN));

   wire [6:0] pins0 = {cs0, rd0, wr0, oe0, busy0, gnt0};
   wire [6:0] pins2 = {cs2, rd2, wr2, oe2, busy2, gnt2};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected {CS,RD,WR,D_OE,BUSY,GNT} n cycles after the edge that sampled the request.
   function automatic logic [6:0] exp_pins(int n, int s, int t, int h, logic is_wr, logic w);
      logic act, stb, bsy;
      logic [1:0] g;
      act = (n >= 1) && (n <= s + t + h);
      stb = (n > s) && (n <= s + t);
      bsy = (n <= s + t + h + 1);
      g   = (n == s + t + h + 1) ? (w ? 2'b10 : 2'b01) : 2'b00;
      return {!act, !(stb && !is_wr), !(stb && is_wr), act && is_wr, bsy, g};
   endfunction

   task automatic do_reset();
      REQ = 2'b00;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b0; REQ = 2'b00; REQ_WR = 2'b00; REQ_A = 4'h0; REQ_D = 16'h0; D_IN = 8'h00;
      @(negedge CLK);
      n_chk++; if ({pins0, a0, dout0, rdd0} !== {7'b1110000, 2'b00, 8'h00, 8'h00}) begin n_fail++; $display("FAIL reset_values got=%h exp=%h", {pins0, a0, dout0, rdd0}, {7'b1110000, 2'b00, 8'h00, 8'h00}); end
      RST = 1'b1;
      @(negedge CLK);
      REQ_WR = 2'b01; REQ_A = 4'b0011; REQ_D = 16'h00A5; REQ = 2'b01;
      repeat (3) @(negedge CLK);
      n_chk++; if ({cs0, wr0} !== 2'b00) begin n_fail++; $display("FAIL reset_pre_strobe got=%b exp=00", {cs0, wr0}); end
      RST = 1'b0;
      #1;
      n_chk++; if (pins0 !== 7'b1110000) begin n_fail++; $display("FAIL reset_async got=%b exp=1110000", pins0); end
      REQ = 2'b00;
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         n_chk++; if (pins0 !== 7'b1110000) begin n_fail++; $display("FAIL reset_after cyc=%0d got=%b exp=1110000", i, pins0); end
      end
   endtask

   task automatic test_single_write();
      do_reset();
      REQ_WR = 2'b01; REQ_A = 4'b0011; REQ_D = 16'h5580; REQ = 2'b01;
      for (int n = 1; n <= 6; n++) begin
         @(negedge CLK);
         n_chk++; if (pins0 !== exp_pins(n, 1, 2, 1, 1'b1, 1'b0)) begin n_fail++; $display("FAIL write_pins n=%0d got=%b exp=%b", n, pins0, exp_pins(n, 1, 2, 1, 1'b1, 1'b0)); end
         if (n <= 4) begin
            n_chk++; if ({a0, dout0} !== {2'b11, 8'h80}) begin n_fail++; $display("FAIL write_bus n=%0d got=%h exp=%h", n, {a0, dout0}, {2'b11, 8'h80}); end
         end
         if (n == 5) REQ = 2'b00;
      end
   endtask

   task automatic test_single_read();
      do_reset();
      D_IN = 8'h11;
      REQ_WR = 2'b01; REQ_A = 4'b0011; REQ_D = 16'h00FF; REQ = 2'b10;
      for (int n = 1; n <= 6; n++) begin
         @(negedge CLK);
         n_chk++; if (pins0 !== exp_pins(n, 1, 2, 1, 1'b0, 1'b1)) begin n_fail++; $display("FAIL read_pins n=%0d got=%b exp=%b", n, pins0, exp_pins(n, 1, 2, 1, 1'b0, 1'b1)); end
         if (n <= 4) begin
            n_chk++; if (a0 !== 2'b00) begin n_fail++; $display("FAIL read_addr n=%0d got=%b exp=00", n, a0); end
         end
         if (n >= 5) begin
            n_chk++; if (rdd0 !== 8'h88) begin n_fail++; $display("FAIL read_data n=%0d got=%h exp=88", n, rdd0); end
         end
         if (n == 3) D_IN = 8'h88;
         if (n == 4) D_IN = 8'h33;
         if (n == 5) REQ = 2'b00;
      end
   endtask

   task automatic test_contention();
      logic exp_w, prev_cs, seen_low, raise;
      int grants, hi_run;
      do_reset();
      REQ_WR = 2'b11; REQ_A = 4'b1001; REQ_D = 16'hB1A0; REQ = 2'b11;
      exp_w = 1'b0; prev_cs = 1'b1; seen_low = 1'b0; raise = 1'b0; grants = 0; hi_run = 0;
      for (int c = 0; c < 60 && grants < 4; c++) begin
         @(negedge CLK);
         if (raise) begin REQ = 2'b11; raise = 1'b0; end
         if (cs0 == 1'b0) begin
            if (prev_cs) begin
               if (seen_low) begin
                  n_chk++; if (hi_run != 2) begin n_fail++; $display("FAIL contention_gap got=%0d exp=2", hi_run); end
               end
               n_chk++; if ({a0, dout0} !== (exp_w ? {2'b10, 8'hB1} : {2'b01, 8'hA0})) begin n_fail++; $display("FAIL contention_cmd got=%h exp_winner=%0d", {a0, dout0}, exp_w); end
            end
            hi_run = 0; seen_low = 1'b1;
         end else begin
            hi_run++;
         end
         prev_cs = cs0;
         if (gnt0 != 2'b00) begin
            n_chk++; if (gnt0 !== (exp_w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_gnt got=%b exp_winner=%0d", gnt0, exp_w); end
            REQ[exp_w] = 1'b0;
            raise = 1'b1;
            exp_w = ~exp_w;
            grants++;
         end
      end
      n_chk++; if (grants != 4) begin n_fail++; $display("FAIL contention_timeout got=%0d exp=4 grants", grants); end
      REQ = 2'b00;
   endtask

   task automatic test_param_sweep();
      do_reset();
      REQ_WR = 2'b01; REQ_A = 4'b0010; REQ_D = 16'h003C; REQ = 2'b01;
      for (int n = 1; n <= 10; n++) begin
         @(negedge CLK);
         n_chk++; if (pins2 !== exp_pins(n, 3, 1, 4, 1'b1, 1'b0)) begin n_fail++; $display("FAIL sweep_pins n=%0d got=%b exp=%b", n, pins2, exp_pins(n, 3, 1, 4, 1'b1, 1'b0)); end
         if (n <= 8) begin
            n_chk++; if ({a2, dout2} !== {2'b10, 8'h3C}) begin n_fail++; $display("FAIL sweep_bus n=%0d got=%h exp=%h", n, {a2, dout2}, {2'b10, 8'h3C}); end
         end
         if (n == 9) REQ = 2'b00;
      end
   endtask

   task automatic test_early_drop();
      int pulses;
      do_reset();
      pulses = 0;
      REQ_WR = 2'b10; REQ_A = 4'b0100; REQ_D = 16'h7700; REQ = 2'b10;
      for (int n = 1; n <= 10; n++) begin
         @(negedge CLK);
         if (n == 1) REQ = 2'b00;
         if (gnt0 != 2'b00) pulses++;
         n_chk++; if (pins0 !== exp_pins(n, 1, 2, 1, 1'b1, 1'b1)) begin n_fail++; $display("FAIL drop_pins n=%0d got=%b exp=%b", n, pins0, exp_pins(n, 1, 2, 1, 1'b1, 1'b1)); end
      end
      n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL drop_gnt_count got=%0d exp=1", pulses); end
   endtask

   task automatic test_random();
      logic ptr, w, is_wr;
      logic [1:0] mask, rwr;
      logic [3:0] ra;
      logic [15:0] rd16;
      logic [7:0] din, last_rd, exp_d;
      do_reset();
      ptr = 1'b0; last_rd = 8'h00;
      for (int t = 0; t < 12; t++) begin
         mask = 2'($urandom_range(1, 3));
         rwr  = 2'($urandom);
         ra   = 4'($urandom);
         rd16 = 16'($urandom);
         din  = 8'($urandom);
         w     = (mask == 2'b11) ? ptr : mask[1];
         is_wr = rwr[w];
         exp_d = w ? rd16[15:8] : rd16[7:0];
         REQ_WR = rwr; REQ_A = ra; REQ_D = rd16; D_IN = din; REQ = mask;
         for (int n = 1; n <= 6; n++) begin
            @(negedge CLK);
            n_chk++; if (pins0 !== exp_pins(n, 1, 2, 1, is_wr, w)) begin n_fail++; $display("FAIL rand_pins t=%0d n=%0d got=%b exp=%b", t, n, pins0, exp_pins(n, 1, 2, 1, is_wr, w)); end
            if (n <= 4) begin
               n_chk++; if (a0 !== (w ? ra[3:2] : ra[1:0])) begin n_fail++; $display("FAIL rand_addr t=%0d n=%0d got=%b exp=%b", t, n, a0, (w ? ra[3:2] : ra[1:0])); end
               if (is_wr) begin
                  n_chk++; if (dout0 !== exp_d) begin n_fail++; $display("FAIL rand_dout t=%0d n=%0d got=%h exp=%h", t, n, dout0, exp_d); end
               end
            end
            if (n == 5) begin
               if (!is_wr) last_rd = din;
               n_chk++; if (rdd0 !== last_rd) begin n_fail++; $display("FAIL rand_rddata t=%0d got=%h exp=%h", t, rdd0, last_rd); end
               REQ = 2'b00;
            end
         end
         ptr = ~w;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_param_sweep();
      test_early_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
